// File: rtl/wvb_storage_managed.sv
// Managed waveform buffer: circular sample RAM plus FWFT header FIFO, with write-address
// generation, free-space tracking, whole-event dropping, length truncation and a drop counter.
module wvb_storage_managed #(
  parameter int P_DATA_WIDTH         = 22,
  parameter int P_ADR_WIDTH          = 12,
  parameter int P_HDR_WIDTH          = 80,
  parameter int P_HDR_DEPTH_LOG2     = 9,
  parameter int P_MAX_WVF_LEN        = 1024,
  parameter int P_N_WVF_IN_BUF_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wvb_wrreq,
  input  logic [P_DATA_WIDTH-1:0]         wvb_data_in,
  input  logic                            eoe_in,
  input  logic [P_HDR_WIDTH-1:0]          hdr_data_in,
  input  logic [P_ADR_WIDTH-1:0]          wvb_rd_addr,
  output logic [P_DATA_WIDTH-1:0]         wvb_data_out,
  input  logic                            hdr_rdreq,
  output logic [P_HDR_WIDTH-1:0]          hdr_data_out,
  output logic [P_ADR_WIDTH-1:0]          hdr_start_addr,
  output logic [P_ADR_WIDTH:0]            hdr_len,
  output logic                            hdr_trunc,
  output logic                            hdr_full,
  output logic                            hdr_empty,
  output logic [P_N_WVF_IN_BUF_WIDTH-1:0] n_wvf_in_buf,
  output logic [15:0]                     n_dropped,
  output logic [P_ADR_WIDTH:0]            wvb_words_used,
  output logic [1:0]                      fsm_state
);
  localparam int DEPTH     = 2**P_ADR_WIDTH;
  localparam int HDR_DEPTH = 2**P_HDR_DEPTH_LOG2;
  localparam int LEN_W     = P_ADR_WIDTH + 1;
  localparam int CNT_W     = P_HDR_DEPTH_LOG2 + 1;
  localparam int ENT_W     = 1 + LEN_W + P_ADR_WIDTH + P_HDR_WIDTH;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(P_MAX_WVF_LEN);
  localparam logic [LEN_W:0]   DEPTH_X = (LEN_W+1)'(DEPTH);
  localparam logic [LEN_W:0]   MAX_X   = (LEN_W+1)'(P_MAX_WVF_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCEPT = 2'd1, DROP = 2'd2, TRUNC = 2'd3} state_t;
  state_t state, state_nxt;

  logic [P_DATA_WIDTH-1:0] ram [DEPTH];
  logic [ENT_W-1:0]        fifo [HDR_DEPTH];

  logic [P_ADR_WIDTH-1:0]      wr_ptr, start, start_nxt;
  logic [LEN_W-1:0]            used, len, len_new;
  logic [15:0]                 drop_cnt;
  logic [P_HDR_DEPTH_LOG2-1:0] f_rd, f_wr;
  logic [CNT_W-1:0]            f_cnt;
  logic [ENT_W-1:0]            head, entry;
  logic [LEN_W-1:0]            head_len;
  logic [LEN_W:0]              free;
  logic [P_DATA_WIDTH-1:0]     wr_word;
  logic admit, do_write, do_commit, do_trunc, do_drop, pop;

  // wvb_wrreq is a valid with no back-pressure: every sample is taken and either stored
  // or discarded internally; hdr_rdreq pops the head only while hdr_empty is low.
  assign free      = DEPTH_X - {1'b0, used};
  assign hdr_empty = (f_cnt == '0);
  assign hdr_full  = (f_cnt == CNT_W'(HDR_DEPTH));
  assign admit     = (free >= MAX_X) && !hdr_full;
  assign pop       = hdr_rdreq && !hdr_empty;
  assign head      = fifo[f_rd];
  assign head_len  = head[ENT_W-2 -: LEN_W];

  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    do_commit = 1'b0;
    do_trunc  = 1'b0;
    do_drop   = 1'b0;
    start_nxt = start;
    len_new   = len + 1'b1;
    if (wvb_wrreq) begin
      if (state == ACCEPT || (state == IDLE && admit)) begin
        do_write = 1'b1;
        if (state == IDLE) begin
          start_nxt = wr_ptr;
          len_new   = LEN_W'(1);
        end
        if (eoe_in) begin
          do_commit = 1'b1;
          state_nxt = IDLE;
        end else if (len_new == MAX_LEN) begin
          do_commit = 1'b1;
          do_trunc  = 1'b1;
          state_nxt = TRUNC;
        end else begin
          state_nxt = ACCEPT;
        end
      end else if (state == IDLE) begin
        do_drop   = 1'b1;
        state_nxt = eoe_in ? IDLE : DROP;
      end else if (eoe_in) begin
        state_nxt = IDLE;
      end
    end
  end

  // Bit 0 of every stored word carries the end-of-event marker, forced on truncation.
  always_comb begin
    wr_word    = wvb_data_in;
    wr_word[0] = eoe_in || do_trunc;
  end

  assign entry = {do_trunc, len_new, start_nxt, hdr_data_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      used     <= '0;
      len      <= '0;
      start    <= '0;
      drop_cnt <= '0;
      f_rd     <= '0;
      f_wr     <= '0;
      f_cnt    <= '0;
    end else begin
      state <= state_nxt;
      used  <= used + LEN_W'(do_write) - (pop ? head_len : '0);
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
        len    <= len_new;
        start  <= start_nxt;
      end
      if (do_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (do_commit) f_wr <= f_wr + 1'b1;
      if (pop) f_rd <= f_rd + 1'b1;
      f_cnt <= f_cnt + CNT_W'(do_commit) - CNT_W'(pop);
    end
  end

  // Storage arrays are never reset; read-before-write gives old data on a same-address hit.
  always_ff @(posedge clk) begin
    if (do_write && !rst) ram[wr_ptr] <= wr_word;
    if (do_commit && !rst) fifo[f_wr] <= entry;
    wvb_data_out <= ram[wvb_rd_addr];
  end

  assign hdr_data_out   = hdr_empty ? '0 : head[P_HDR_WIDTH-1:0];
  assign hdr_start_addr = hdr_empty ? '0 : head[P_HDR_WIDTH +: P_ADR_WIDTH];
  assign hdr_len        = hdr_empty ? '0 : head_len;
  assign hdr_trunc      = hdr_empty ? 1'b0 : head[ENT_W-1];
  assign n_wvf_in_buf   = P_N_WVF_IN_BUF_WIDTH'(f_cnt);
  assign n_dropped      = drop_cnt;
  assign wvb_words_used = used;
  assign fsm_state      = state;
endmodule

// File: tb/tb_wvb_storage_managed.sv
// Directed bench for wvb_storage_managed: a default-size instance and a 4-entry header FIFO
// instance share all inputs; expected values are hand-computed per step.
module tb_wvb_storage_managed;
  localparam int DW = 22, AW = 12, HW = 80, NW = 16;

  logic          clk = 1'b0;
  logic          rst, wvb_wrreq, eoe_in, hdr_rdreq;
  logic [DW-1:0] wvb_data_in;
  logic [HW-1:0] hdr_data_in;
  logic [AW-1:0] wvb_rd_addr;

  logic [DW-1:0] a_data_out, b_data_out;
  logic [HW-1:0] a_hdr_data, b_hdr_data;
  logic [AW-1:0] a_start, b_start;
  logic [AW:0]   a_len, b_len, a_used, b_used;
  logic          a_trunc, b_trunc, a_full, b_full, a_empty, b_empty;
  logic [NW-1:0] a_nwvf, b_nwvf;
  logic [15:0]   a_ndrop, b_ndrop;
  logic [1:0]    a_fsm, b_fsm;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wvb_storage_managed dut_a (
    .clk(clk), .rst(rst), .wvb_wrreq(wvb_wrreq), .wvb_data_in(wvb_data_in), .eoe_in(eoe_in),
    .hdr_data_in(hdr_data_in), .wvb_rd_addr(wvb_rd_addr), .wvb_data_out(a_data_out),
    .hdr_rdreq(hdr_rdreq), .hdr_data_out(a_hdr_data), .hdr_start_addr(a_start), .hdr_len(a_len),
    .hdr_trunc(a_trunc), .hdr_full(a_full), .hdr_empty(a_empty), .n_wvf_in_buf(a_nwvf),
    .n_dropped(a_ndrop), .wvb_words_used(a_used), .fsm_state(a_fsm)
  );

  wvb_storage_managed #(.P_HDR_DEPTH_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .wvb_wrreq(wvb_wrreq), .wvb_data_in(wvb_data_in), .eoe_in(eoe_in),
    .hdr_data_in(hdr_data_in), .wvb_rd_addr(wvb_rd_addr), .wvb_data_out(b_data_out),
    .hdr_rdreq(hdr_rdreq), .hdr_data_out(b_hdr_data), .hdr_start_addr(b_start), .hdr_len(b_len),
    .hdr_trunc(b_trunc), .hdr_full(b_full), .hdr_empty(b_empty), .n_wvf_in_buf(b_nwvf),
    .n_dropped(b_ndrop), .wvb_words_used(b_used), .fsm_state(b_fsm)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wvb_wrreq = 1'b0; eoe_in = 1'b0; hdr_rdreq = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [DW-1:0] base, input logic b0,
                            input logic eoe_last, input logic [HW-1:0] hdr);
    for (int i = 0; i < n; i++) begin
      wvb_wrreq   = 1'b1;
      wvb_data_in = (base + DW'(2 * i)) | DW'(b0);
      eoe_in      = eoe_last && (i == n - 1);
      hdr_data_in = hdr;
      @(posedge clk); #1;
    end
    wvb_wrreq = 1'b0;
    eoe_in    = 1'b0;
  endtask

  task automatic pop();
    hdr_rdreq = 1'b1;
    @(posedge clk); #1;
    hdr_rdreq = 1'b0;
  endtask

  task automatic read_ram(input logic [AW-1:0] addr);
    wvb_rd_addr = addr;
    @(posedge clk); #1;
  endtask

  initial begin
    wvb_data_in = '0; hdr_data_in = '0; wvb_rd_addr = '0;
    do_reset();

    // reset state
    check("rst_empty", 128'(a_empty), 128'(1));
    check("rst_full", 128'(a_full), 128'(0));
    check("rst_nwvf", 128'(a_nwvf), 128'(0));
    check("rst_ndrop", 128'(a_ndrop), 128'(0));
    check("rst_used", 128'(a_used), 128'(0));
    check("rst_len", 128'(a_len), 128'(0));
    check("rst_hdr", 128'(a_hdr_data), 128'(0));
    check("rst_fsm", 128'(a_fsm), 128'(0));
    check("rst_b_empty", 128'(b_empty), 128'(1));

    // small header FIFO: four one-word events fill it, the fifth is dropped
    for (int k = 0; k < 4; k++) send_words(1, 22'h100, 1'b0, 1'b1, HW'(8'h10 + k));
    check("b_full4", 128'(b_full), 128'(1));
    check("b_nwvf4", 128'(b_nwvf), 128'(4));
    check("a_full4", 128'(a_full), 128'(0));
    send_words(1, 22'h100, 1'b0, 1'b1, HW'(8'h14));
    check("b_drop5", 128'(b_ndrop), 128'(1));
    check("b_nwvf5", 128'(b_nwvf), 128'(4));
    check("b_used5", 128'(b_used), 128'(4));
    check("a_nwvf5", 128'(a_nwvf), 128'(5));
    check("a_ndrop5", 128'(a_ndrop), 128'(0));
    check("b_head_len", 128'(b_len), 128'(1));
    check("b_head_hdr", 128'(b_hdr_data), 128'(8'h10));
    pop();
    check("a_nwvf_pop", 128'(a_nwvf), 128'(4));
    check("b_nwvf_pop", 128'(b_nwvf), 128'(3));
    check("b_notfull", 128'(b_full), 128'(0));
    // two-word event whose eoe coincides with a pop
    send_words(1, 22'h200, 1'b0, 1'b0, HW'(8'h20));
    check("a_used_mid", 128'(a_used), 128'(5));
    check("a_fsm_accept", 128'(a_fsm), 128'(1));
    wvb_wrreq = 1'b1; eoe_in = 1'b1; wvb_data_in = 22'h202; hdr_data_in = HW'(8'h20);
    hdr_rdreq = 1'b1;
    @(posedge clk); #1;
    wvb_wrreq = 1'b0; eoe_in = 1'b0; hdr_rdreq = 1'b0;
    check("a_nwvf_popcommit", 128'(a_nwvf), 128'(4));
    check("a_used_popcommit", 128'(a_used), 128'(5));
    check("b_nwvf_popcommit", 128'(b_nwvf), 128'(3));
    check("b_used_popcommit", 128'(b_used), 128'(4));
    check("a_head_start", 128'(a_start), 128'(2));
    check("a_head_hdr", 128'(a_hdr_data), 128'(8'h12));

    // 8-word event with header 0xAB
    do_reset();
    send_words(7, 22'h15500, 1'b1, 1'b0, HW'(8'hAB));
    check("t1_empty_before", 128'(a_empty), 128'(1));
    send_words(1, 22'h1550E, 1'b1, 1'b1, HW'(8'hAB));
    check("t1_empty", 128'(a_empty), 128'(0));
    check("t1_start", 128'(a_start), 128'(0));
    check("t1_len", 128'(a_len), 128'(8));
    check("t1_trunc", 128'(a_trunc), 128'(0));
    check("t1_nwvf", 128'(a_nwvf), 128'(1));
    check("t1_hdr", 128'(a_hdr_data), 128'(8'hAB));
    check("t1_used", 128'(a_used), 128'(8));
    read_ram(12'd7);
    check("t1_ram7", 128'(a_data_out), 128'(22'h1550F));
    wvb_rd_addr = 12'd3;
    #1 check("t6_ram3_latency", 128'(a_data_out), 128'(22'h1550F));
    @(posedge clk); #1;
    check("t6_ram3", 128'(a_data_out), 128'(22'h15506));

    // truncation at 1024 words, remaining six discarded
    do_reset();
    send_words(1024, 22'h0, 1'b0, 1'b0, HW'(8'h33));
    check("t3_fsm_trunc", 128'(a_fsm), 128'(3));
    check("t3_len", 128'(a_len), 128'(1024));
    check("t3_trunc", 128'(a_trunc), 128'(1));
    send_words(6, 22'h3000, 1'b0, 1'b1, HW'(8'h33));
    check("t3_fsm_idle", 128'(a_fsm), 128'(0));
    check("t3_used", 128'(a_used), 128'(1024));
    check("t3_nwvf", 128'(a_nwvf), 128'(1));
    check("t3_ndrop", 128'(a_ndrop), 128'(0));
    read_ram(12'd1023);
    check("t3_ram1023", 128'(a_data_out), 128'(22'h7FF));
    read_ram(12'd1022);
    check("t3_ram1022", 128'(a_data_out), 128'(22'h7FC));
    pop();
    check("t3_used_pop", 128'(a_used), 128'(0));
    send_words(1, 22'h40, 1'b0, 1'b1, HW'(8'h77));
    check("t3_next_start", 128'(a_start), 128'(1024));

    // reset in the middle of an event
    do_reset();
    send_words(4, 22'h500, 1'b0, 1'b0, HW'(8'h55));
    check("t5_used_mid", 128'(a_used), 128'(4));
    rst = 1'b1; wvb_wrreq = 1'b1; wvb_data_in = 22'h508;
    @(posedge clk); #1;
    rst = 1'b0; wvb_wrreq = 1'b0;
    check("t5_used", 128'(a_used), 128'(0));
    check("t5_empty", 128'(a_empty), 128'(1));
    check("t5_fsm", 128'(a_fsm), 128'(0));
    check("t5_ndrop", 128'(a_ndrop), 128'(0));
    send_words(2, 22'h600, 1'b0, 1'b1, HW'(8'h56));
    check("t5_start", 128'(a_start), 128'(0));
    check("t5_len", 128'(a_len), 128'(2));

    // free-space drop and wrap-around
    do_reset();
    for (int k = 0; k < 4; k++) send_words(1000, 22'h0, 1'b0, 1'b1, HW'(8'hE0 + k));
    check("t2_used4", 128'(a_used), 128'(4000));
    send_words(1, 22'h0, 1'b0, 1'b0, HW'(8'hE4));
    check("t2_fsm_drop", 128'(a_fsm), 128'(2));
    check("t2_ndrop", 128'(a_ndrop), 128'(1));
    send_words(9, 22'h0, 1'b0, 1'b1, HW'(8'hE4));
    check("t2_fsm_idle", 128'(a_fsm), 128'(0));
    check("t2_used_drop", 128'(a_used), 128'(4000));
    check("t2_nwvf_drop", 128'(a_nwvf), 128'(4));
    pop();
    check("t2_used_pop", 128'(a_used), 128'(3000));
    send_words(1000, 22'h0, 1'b0, 1'b1, HW'(8'hE6));
    check("t2_used6", 128'(a_used), 128'(4000));
    check("t2_ndrop6", 128'(a_ndrop), 128'(1));
    repeat (3) pop();
    check("t2_start6", 128'(a_start), 128'(4000));
    check("t2_len6", 128'(a_len), 128'(1000));
    check("t2_hdr6", 128'(a_hdr_data), 128'(8'hE6));
    read_ram(12'd4095);
    check("t2_ram4095", 128'(a_data_out), 128'(22'hBE));
    read_ram(12'd0);
    check("t2_ram0", 128'(a_data_out), 128'(22'hC0));
    read_ram(12'd903);
    check("t2_ram903", 128'(a_data_out), 128'(22'h7CF));
    send_words(1, 22'h0, 1'b0, 1'b1, HW'(8'hE7));
    pop();
    check("t2_next_start", 128'(a_start), 128'(904));
    check("t2_used_end", 128'(a_used), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
